// File: rtl/cnn_accel_pkg.sv
// Shared CNN accelerator definitions: sequencer state encoding and default dimensions.
package cnn_accel_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } conv_state_e;

  localparam int unsigned VECTOR_SIZE_DEF = 8;
  localparam int unsigned DIM_WIDTH_DEF   = 8;
  localparam int unsigned ADDR_WIDTH_DEF  = 12;

endpackage

// File: rtl/conv_loop_counter.sv
// One nested-loop level: counts 0..limit on each enable, o_wrap flags the terminal count.
module conv_loop_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clr,
  input  logic             i_inc,
  input  logic [WIDTH-1:0] i_limit,
  output logic [WIDTH-1:0] o_count,
  output logic             o_wrap
);

  logic [WIDTH-1:0] r_count;

  assign o_wrap  = (r_count == i_limit);
  assign o_count = r_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc) begin
      r_count <= o_wrap ? '0 : r_count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/conv_window_sequencer.sv
// Stride-1 valid-convolution address sequencer feeding the MAC read ports.
// Optional stall-cycle counter port enabled by defining CONV_STALL_CNT_EN.
module conv_window_sequencer
  import cnn_accel_pkg::*;
#(
  parameter int unsigned VECTOR_SIZE = VECTOR_SIZE_DEF,
  parameter int unsigned DIM_WIDTH   = DIM_WIDTH_DEF,
  parameter int unsigned ADDR_WIDTH  = ADDR_WIDTH_DEF
) (
  input  logic                   clkIn,
  input  logic                   rstIn,
  input  logic                   startIn,
  input  logic [DIM_WIDTH-1:0]   filtRowsIn,
  input  logic [DIM_WIDTH-1:0]   filtColsIn,
  input  logic [DIM_WIDTH-1:0]   dataRowsIn,
  input  logic [DIM_WIDTH-1:0]   dataColsIn,
  output logic                   busyOut,
  output logic                   doneOut,
  output logic                   errOut,
  output logic                   validOut,
  input  logic                   readyIn,
  output logic [ADDR_WIDTH-1:0]  dataAddrOut,
  output logic [ADDR_WIDTH-1:0]  filtAddrOut,
  output logic [VECTOR_SIZE-1:0] laneMaskOut,
  output logic                   lastOut
`ifdef CONV_STALL_CNT_EN
  ,
  output logic [31:0]            stallCountOut
`endif
);

  localparam int unsigned AW = 2 * DIM_WIDTH + 1;
  localparam logic [AW-1:0] AREA_MAX = AW'(1 << ADDR_WIDTH);

  conv_state_e r_state, w_stateNext;

  logic [ADDR_WIDTH-1:0] r_dCols, r_fCols, r_fc;
  logic [ADDR_WIDTH-1:0] r_dataAddr, r_filtAddr;
  logic [ADDR_WIDTH-1:0] r_rowBase, r_pixBase, r_outRowBase, r_filtRowBase;
  logic [DIM_WIDTH-1:0]  r_rowLim, r_colLim, r_frLim, r_cLim;
  logic                  r_valid, r_err;

  logic                  w_startIdle, w_reject, w_accept, w_xfer, w_finalBeat;
  logic                  w_cWrap, w_frWrap, w_colWrap, w_rowWrap;
  logic [AW-1:0]         w_area;
  logic [ADDR_WIDTH-1:0] w_rowBaseNext, w_filtBaseNext, w_pixNext, w_outRowNext;
  logic [VECTOR_SIZE-1:0] w_mask;
  // Loop indices live implicitly in the address registers; only terminal flags are consumed.
  logic [3:0][DIM_WIDTH-1:0] w_cnt_unused;

  assign w_startIdle = (r_state == ST_IDLE) && startIn;
  assign w_area      = AW'(dataRowsIn) * AW'(dataColsIn);
  assign w_reject    = (filtRowsIn == '0) || (filtColsIn == '0) ||
                       (dataRowsIn == '0) || (dataColsIn == '0) ||
                       (filtRowsIn > dataRowsIn) || (filtColsIn > dataColsIn) ||
                       (w_area > AREA_MAX);
  assign w_accept    = w_startIdle && !w_reject;
  assign w_xfer      = r_valid && readyIn;
  assign w_finalBeat = w_cWrap && w_frWrap && w_colWrap && w_rowWrap;

  conv_loop_counter #(.WIDTH(DIM_WIDTH)) u_chunk (
    .i_clk(clkIn), .i_rst_n(rstIn), .i_clr(w_accept), .i_inc(w_xfer),
    .i_limit(r_cLim), .o_count(w_cnt_unused[0]), .o_wrap(w_cWrap)
  );
  conv_loop_counter #(.WIDTH(DIM_WIDTH)) u_frow (
    .i_clk(clkIn), .i_rst_n(rstIn), .i_clr(w_accept), .i_inc(w_xfer && w_cWrap),
    .i_limit(r_frLim), .o_count(w_cnt_unused[1]), .o_wrap(w_frWrap)
  );
  conv_loop_counter #(.WIDTH(DIM_WIDTH)) u_ocol (
    .i_clk(clkIn), .i_rst_n(rstIn), .i_clr(w_accept),
    .i_inc(w_xfer && w_cWrap && w_frWrap),
    .i_limit(r_colLim), .o_count(w_cnt_unused[2]), .o_wrap(w_colWrap)
  );
  conv_loop_counter #(.WIDTH(DIM_WIDTH)) u_orow (
    .i_clk(clkIn), .i_rst_n(rstIn), .i_clr(w_accept),
    .i_inc(w_xfer && w_cWrap && w_frWrap && w_colWrap),
    .i_limit(r_rowLim), .o_count(w_cnt_unused[3]), .o_wrap(w_rowWrap)
  );

  always_ff @(posedge clkIn or negedge rstIn) begin
    if (!rstIn) r_state <= ST_IDLE;
    else        r_state <= w_stateNext;
  end

  always_comb begin
    w_stateNext = r_state;
    busyOut     = 1'b0;
    doneOut     = 1'b0;
    case (r_state)
      ST_IDLE: if (w_accept) w_stateNext = ST_RUN;
      ST_RUN: begin
        busyOut = 1'b1;
        if (w_xfer && w_finalBeat) w_stateNext = ST_DONE;
      end
      ST_DONE: begin
        doneOut     = 1'b1;
        w_stateNext = ST_IDLE;
      end
      default: w_stateNext = ST_IDLE;
    endcase
  end

  assign w_rowBaseNext  = r_rowBase + r_dCols;
  assign w_filtBaseNext = r_filtRowBase + r_fCols;
  assign w_pixNext      = r_pixBase + ADDR_WIDTH'(1);
  assign w_outRowNext   = r_outRowBase + r_dCols;

  always_ff @(posedge clkIn or negedge rstIn) begin
    if (!rstIn) begin
      r_dCols       <= '0;
      r_fCols       <= '0;
      r_rowLim      <= '0;
      r_colLim      <= '0;
      r_frLim       <= '0;
      r_cLim        <= '0;
      r_fc          <= '0;
      r_dataAddr    <= '0;
      r_filtAddr    <= '0;
      r_rowBase     <= '0;
      r_pixBase     <= '0;
      r_outRowBase  <= '0;
      r_filtRowBase <= '0;
      r_valid       <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      r_err <= w_startIdle && w_reject;
      if (w_startIdle) begin
        r_dCols  <= ADDR_WIDTH'(dataColsIn);
        r_fCols  <= ADDR_WIDTH'(filtColsIn);
        r_rowLim <= dataRowsIn - filtRowsIn;
        r_colLim <= dataColsIn - filtColsIn;
        r_frLim  <= filtRowsIn - DIM_WIDTH'(1);
        r_cLim   <= DIM_WIDTH'((32'(filtColsIn) - 32'd1) / VECTOR_SIZE);
      end
      if (w_accept) begin
        r_fc          <= '0;
        r_dataAddr    <= '0;
        r_filtAddr    <= '0;
        r_rowBase     <= '0;
        r_pixBase     <= '0;
        r_outRowBase  <= '0;
        r_filtRowBase <= '0;
        r_valid       <= 1'b1;
      end else if (w_xfer) begin
        // Innermost level that has not wrapped decides which base reloads the lane-0 addresses.
        if (!w_cWrap) begin
          r_fc       <= r_fc + ADDR_WIDTH'(VECTOR_SIZE);
          r_dataAddr <= r_dataAddr + ADDR_WIDTH'(VECTOR_SIZE);
          r_filtAddr <= r_filtAddr + ADDR_WIDTH'(VECTOR_SIZE);
        end else if (!w_frWrap) begin
          r_fc          <= '0;
          r_rowBase     <= w_rowBaseNext;
          r_dataAddr    <= w_rowBaseNext;
          r_filtRowBase <= w_filtBaseNext;
          r_filtAddr    <= w_filtBaseNext;
        end else if (!w_colWrap) begin
          r_fc          <= '0;
          r_pixBase     <= w_pixNext;
          r_rowBase     <= w_pixNext;
          r_dataAddr    <= w_pixNext;
          r_filtRowBase <= '0;
          r_filtAddr    <= '0;
        end else if (!w_rowWrap) begin
          r_fc          <= '0;
          r_outRowBase  <= w_outRowNext;
          r_pixBase     <= w_outRowNext;
          r_rowBase     <= w_outRowNext;
          r_dataAddr    <= w_outRowNext;
          r_filtRowBase <= '0;
          r_filtAddr    <= '0;
        end else begin
          r_valid <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    w_mask = '0;
    for (int unsigned i = 0; i < VECTOR_SIZE; i++) begin
      w_mask[i] = r_valid && ((r_fc + ADDR_WIDTH'(i)) < r_fCols);
    end
  end

  assign validOut    = r_valid;
  assign errOut      = r_err;
  assign dataAddrOut = r_dataAddr;
  assign filtAddrOut = r_filtAddr;
  assign laneMaskOut = w_mask;
  assign lastOut     = r_valid && w_cWrap && w_frWrap;

`ifdef CONV_STALL_CNT_EN
  logic [31:0] r_stallCnt;

  always_ff @(posedge clkIn or negedge rstIn) begin
    if (!rstIn) begin
      r_stallCnt <= '0;
    end else if (w_accept) begin
      r_stallCnt <= '0;
    end else if (r_valid && !readyIn && (r_stallCnt != '1)) begin
      r_stallCnt <= r_stallCnt + 32'd1;
    end
  end

  assign stallCountOut = r_stallCnt;
`endif

endmodule
